// File: rtl/sr_pkg.sv
// sr_pkg: shared FSM state type and error-counter sizing for sr_exc_driver.
// The CHECK state exists only when SR_EXC_CHECK_EN is defined.
package sr_pkg;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

`ifdef SR_EXC_CHECK_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1
    } state_e;
`endif

endpackage

// File: rtl/sr_exc_logic.sv
// sr_exc_logic: one-bit SR excitation. Set only for a 0->1 move, Reset only
// for a 1->0 move; hold and don't-care cases resolve to S=R=0, so the
// forbidden S=R=1 pair can never be produced.
module sr_exc_logic (
    input  logic tgt,
    input  logic q,
    output logic s,
    output logic r
);

    assign s = tgt & ~q;
    assign r = ~tgt & q;

endmodule

// File: rtl/sr_exc_driver.sv
// sr_exc_driver: accepts a target word, drives a bank of SR flip-flops toward
// it for one cycle with minimal excitations, then reports completion.
// Optional feature: define SR_EXC_CHECK_EN to build the CHECK state, which
// compares the bank against the target and drives err_o / err_cnt_o.
module sr_exc_driver
    import sr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tgt_valid_i,
    output logic                 tgt_ready_o,
    input  logic [WIDTH-1:0]     tgt_data_i,
    input  logic [WIDTH-1:0]     q_i,
    output logic [WIDTH-1:0]     s_o,
    output logic [WIDTH-1:0]     r_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    state_e           state;
    state_e           state_nxt;
    logic [WIDTH-1:0] s_exc;
    logic [WIDTH-1:0] r_exc;
    logic             accept;
    logic             done_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_exc
        sr_exc_logic u_exc (
            .tgt (tgt_data_i[i]),
            .q   (q_i[i]),
            .s   (s_exc[i]),
            .r   (r_exc[i])
        );
    end

    assign tgt_ready_o = (state == ST_IDLE);
    assign accept      = tgt_ready_o && tgt_valid_i;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state <= state_nxt;
        end
    end

    // Next-state: IDLE -> DRIVE -> (CHECK ->) IDLE.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            ST_IDLE:  if (tgt_valid_i) state_nxt = ST_DRIVE;
`ifdef SR_EXC_CHECK_EN
            ST_DRIVE: state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = ST_IDLE;
`else
            ST_DRIVE: state_nxt = ST_IDLE;
`endif
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Excitations are registered at acceptance and live for the DRIVE cycle only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_o <= '0;
            r_o <= '0;
        end else begin
            s_o <= accept ? s_exc : '0;
            r_o <= accept ? r_exc : '0;
        end
    end

`ifdef SR_EXC_CHECK_EN
    logic [WIDTH-1:0]     tgt_q;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 mismatch;

    assign mismatch = (q_i != tgt_q);

    // Hold the target, grade the bank in CHECK, and count misses (saturating).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (accept) begin
                tgt_q <= tgt_data_i;
            end
            done_q <= (state == ST_CHECK) && !mismatch;
            err_q  <= (state == ST_CHECK) && mismatch;
            if ((state == ST_CHECK) && mismatch && (err_cnt_q != ERR_CNT_MAX)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
`else
    // Without grading, completion is reported straight after DRIVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state == ST_DRIVE);
        end
    end

    assign err_o     = 1'b0;
    assign err_cnt_o = '0;
`endif

    assign done_o = done_q;

endmodule

// File: doc/sr_exc_driver.md
SR_EXC_DRIVER -- requirements
Module: sr_exc_driver

Interface
REQ-001 Parameter WIDTH, default 8: number of SR flip-flops in the driven register bank.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 tgt_valid_i  input  1  target value offered.
REQ-005 tgt_ready_o  output  1  block can accept a target.
REQ-006 tgt_data_i  input  WIDTH  desired next state of the SR bank.
REQ-007 q_i  input  WIDTH  current outputs of the driven SR bank.
REQ-008 s_o  output  WIDTH  per-bit Set excitation to the bank.
REQ-009 r_o  output  WIDTH  per-bit Reset excitation to the bank.
REQ-010 done_o  output  1  one-cycle pulse: transfer completed.
REQ-011 err_o  output  1  one-cycle pulse: bank did not reach target.
REQ-012 err_cnt_o  output  8  saturating count of err_o pulses.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE and CHECK.
REQ-014 tgt_ready_o SHALL be 1 in IDLE only; a transfer is accepted on a rising edge with tgt_valid_i=1 in IDLE.
REQ-015 On acceptance, the block SHALL capture tgt_data_i into tgt_q, register s_o = tgt_data_i & ~q_i and r_o = ~tgt_data_i & q_i, and enter DRIVE.
REQ-016 Don't-care excitations SHALL resolve to 0: hold and already-at-target bits drive s=0, r=0.
REQ-017 s_o & r_o SHALL equal 0 in every cycle; the forbidden S=R=1 combination is never driven.
REQ-018 DRIVE SHALL last exactly one cycle; s_o/r_o are nonzero only in DRIVE and clear to 0 on exit.
REQ-019 DRIVE SHALL go to CHECK; CHECK SHALL last one cycle and compare q_i with tgt_q.
REQ-020 On leaving CHECK, match SHALL give done_o=1 in the next cycle; mismatch SHALL give err_o=1 in the next cycle and err_cnt_o+1, saturating at 255.
REQ-021 CHECK SHALL always return to IDLE. A new transfer may be accepted in the same cycle done_o or err_o is high.
REQ-022 A target equal to q_i SHALL still run the full sequence (DRIVE with zeros) and end in done_o.
REQ-023 Latency: acceptance at edge E0 -> DRIVE E0..E1 -> CHECK E1..E2 -> done_o/err_o high E2..E3.
REQ-024 While not ready, the upstream SHALL hold tgt_valid_i and tgt_data_i stable; changes to tgt_data_i outside acceptance SHALL be ignored.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, s_o=0, r_o=0, done_o=0, err_o=0, err_cnt_o=0 and tgt_q=0, including mid-DRIVE or mid-CHECK.
REQ-026 tgt_ready_o SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-027 Macro SR_EXC_CHECK_EN defined: the CHECK state, err_o and err_cnt_o behave as in REQ-019..REQ-020.
REQ-028 SR_EXC_CHECK_EN undefined: DRIVE SHALL go directly to IDLE with done_o high the next cycle (E1..E2); err_o and err_cnt_o SHALL be constant 0; no CHECK state is built.

Structure
REQ-029 Shared package sr_pkg SHALL hold the FSM state typedef and the constant ERR_CNT_W=8.
REQ-030 Per-bit excitation SHALL be the combinational sub-module sr_exc_logic (inputs tgt, q; outputs s, r), instantiated WIDTH-wide.

Verification (WIDTH=8, bench models the SR bank as q <= s | (~r & q))
REQ-031 q_i=0x00, send 0xA5 -> DRIVE shows s_o=0xA5, r_o=0x00; done_o high E2..E3; q=0xA5.
REQ-032 q_i=0xFF, send 0x0F -> s_o=0x00, r_o=0xF0; done_o pulses; q=0x0F.
REQ-033 q_i=0x3C, send 0x3C -> s_o=r_o=0x00 in DRIVE; done_o pulses; err_cnt_o stays 0.
REQ-034 Bank stuck at 0x00, send 0x01 -> err_o pulses and err_cnt_o=1; after 300 such transfers err_cnt_o=255.
REQ-035 Assert rst during DRIVE -> s_o=r_o=0 before the next edge; after release tgt_ready_o=1 and err_cnt_o=0.
REQ-036 SR_EXC_CHECK_EN undefined, send 0x81 from 0x00 -> done_o high E1..E2; err_o never asserts.
